// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder.
// One group of GROUP_W bits is resolved per pipeline stage.
package cla_pkg;

    localparam int GROUP_W_DEF = 4;

    typedef struct packed {
        logic valid;
        logic carry;
        logic c_msb;
        logic zero;
    } stage_ctl_t;

    function automatic int num_groups(input int width, input int group_w);
        int n;
        n = (group_w < 1) ? 1 : width / group_w;
        return (n < 1) ? 1 : n;
    endfunction

endpackage

// File: rtl/cla_pipe_adder_group.sv
// Combinational GROUP_W-bit carry-lookahead group.
// Exports sum, carry-out, group propagate/generate and carry into the MSB.
module cla_group #(
    parameter int GW = 4
) (
    input  logic [GW-1:0] a,
    input  logic [GW-1:0] b,
    input  logic          cin,
    output logic [GW-1:0] sum,
    output logic          cout,
    output logic          grp_p,
    output logic          grp_g,
    output logic          c_msb
);

    logic [GW-1:0] p;
    logic [GW-1:0] g;
    logic [GW:0]   c;
    logic          gg;

    always_comb begin
        p    = a ^ b;
        g    = a & b;
        c    = '0;
        c[0] = cin;
        gg   = 1'b0;
        for (int i = 0; i < GW; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
            gg     = g[i] | (p[i] & gg);
        end
        sum   = p ^ c[GW-1:0];
        cout  = c[GW];
        grp_p = &p;
        grp_g = gg;
        c_msb = c[GW-1];
    end

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Latency is NUM_GROUPS cycles; a stall freezes every stage together.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int GROUP_W = GROUP_W_DEF
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    input  logic             Cin_in,
    input  logic             Sub_in,
    input  logic             Valid_in,
    output logic             Ready_out,
    output logic [WIDTH-1:0] S_out,
    output logic             Cout_out,
    output logic             Ovf_out,
    output logic             Zero_out,
    output logic             Valid_out,
    input  logic             Ready_in
);

    localparam int NUM_GROUPS = num_groups(WIDTH, GROUP_W);
    localparam int GW_SAFE    = (GROUP_W < 1) ? 1 : GROUP_W;

    if ((GROUP_W < 1) || (WIDTH % GW_SAFE != 0)) begin : g_bad_cfg
        $error("cla_pipe_adder: WIDTH must be a multiple of GROUP_W >= 1");
    end

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
        stage_ctl_t       ctl;
    } stage_t;

    localparam int LAST = NUM_GROUPS - 1;

    stage_t r [NUM_GROUPS];
    stage_t in_st;
    logic   stall;

    assign stall     = r[LAST].ctl.valid & ~Ready_in;
    assign Ready_out = ~stall;

    always_comb begin
        in_st           = '0;
        in_st.a         = A_in;
        in_st.b         = Sub_in ? ~B_in : B_in;
        in_st.ctl.valid = Valid_in;
        in_st.ctl.carry = Sub_in | Cin_in;
    end

    for (genvar k = 0; k < NUM_GROUPS; k++) begin : g_stage
        stage_t             src;
        stage_t             nxt;
        logic [GW_SAFE-1:0] sum;
        logic               cout;
        logic               gp;
        logic               gg;
        logic               cm;

        if (k == 0) begin : g_first
            assign src = in_st;
        end else begin : g_rest
            assign src = r[k-1];
        end

        cla_group #(.GW(GW_SAFE)) u_grp (
            .a     (src.a[k*GW_SAFE +: GW_SAFE]),
            .b     (src.b[k*GW_SAFE +: GW_SAFE]),
            .cin   (src.ctl.carry),
            .sum   (sum),
            .cout  (cout),
            .grp_p (gp),
            .grp_g (gg),
            .c_msb (cm)
        );

        // Zero reduction only matters once the last group is resolved
        always_comb begin
            nxt                          = src;
            nxt.s[k*GW_SAFE +: GW_SAFE] = sum;
            nxt.ctl.carry                = cout;
            nxt.ctl.c_msb                = cm;
            nxt.ctl.zero                 = (k == LAST) && (nxt.s == '0);
        end

        // Data only moves with a valid beat so outputs hold across bubbles
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                r[k] <= '0;
            end else if (!stall) begin
                r[k].ctl.valid <= src.ctl.valid;
                if (src.ctl.valid) begin
                    r[k] <= nxt;
                end
            end
        end

        always @(posedge CLK) begin
            if (RST_N) begin
                assert (cout == (gg | (gp & src.ctl.carry)));
            end
        end
    end

    assign S_out     = r[LAST].s;
    assign Cout_out  = r[LAST].ctl.carry;
    assign Ovf_out   = r[LAST].ctl.carry ^ r[LAST].ctl.c_msb;
    assign Zero_out  = r[LAST].ctl.zero;
    assign Valid_out = r[LAST].ctl.valid;

endmodule
